clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: start/stop run control plus a valid/ready half-period config port.
// Defining CLK_DIV_CTRL_BURST_EN compiles in burst mode (a run ends after burst_len output periods).
module clk_div_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] burst_len,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] half, half_nxt;
  logic [CNT_W-1:0] half_eff;
  logic [CNT_W-1:0] pend_half, pend_half_nxt;
  logic             pend, pend_nxt;
  logic             clk_out_nxt;
  logic             tick_nxt;
  logic             done_nxt;
  logic             accept;
  logic             at_wrap;
  logic             falling;
  logic             burst_hit;
  logic             go_idle;
  logic             run_req;

  // A programmed half of 0 behaves as 1 so the divider can never stall.
  assign half_eff  = (half == '0) ? CNT_W'(1) : half;
  assign at_wrap   = (count == half_eff - CNT_W'(1));
  assign falling   = at_wrap && clk_out;
  assign cfg_ready = !pend;
  assign accept    = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE);
  assign run_req   = start && !stop;

`ifdef CLK_DIV_CTRL_BURST_EN
  logic [CNT_W-1:0] burst_n;
  logic [CNT_W-1:0] falls;

  // falls counts completed periods of the current run; the Nth falling edge ends it.
  assign burst_hit = (burst_n != '0) && (falls == burst_n - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_n <= '0;
      falls   <= '0;
    end else if (state == IDLE) begin
      falls <= '0;
      if (run_req) begin
        burst_n <= burst_len;
      end
    end else if (falling) begin
      falls <= falls + CNT_W'(1);
    end
  end
`else
  logic unused_burst_len;

  assign burst_hit        = 1'b0;
  assign unused_burst_len = ^burst_len;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt     = state;
    count_nxt     = count;
    half_nxt      = half;
    pend_nxt      = pend;
    pend_half_nxt = pend_half;
    clk_out_nxt   = clk_out;
    tick_nxt      = 1'b0;
    done_nxt      = 1'b0;
    go_idle       = 1'b0;

    case (state)
      IDLE: begin
        count_nxt   = '0;
        clk_out_nxt = 1'b0;
        if (accept) begin
          half_nxt = cfg_half;
        end
        if (run_req) begin
          state_nxt = RUN;
        end
      end

      RUN, STOPPING: begin
        if (state == RUN && stop && !clk_out) begin
          // Output is already low: end now and suppress any rising toggle due this cycle.
          go_idle = 1'b1;
        end else if (at_wrap) begin
          clk_out_nxt = !clk_out;
          tick_nxt    = 1'b1;
          count_nxt   = '0;
          if (pend) begin
            half_nxt = pend_half;
            pend_nxt = 1'b0;
          end
          if (clk_out && (state == STOPPING || stop || burst_hit)) begin
            go_idle = 1'b1;
          end
        end else begin
          count_nxt = count + CNT_W'(1);
          if (state == RUN && stop) begin
            state_nxt = STOPPING;
          end
        end

        if (accept) begin
          pend_nxt      = 1'b1;
          pend_half_nxt = cfg_half;
        end

        // A config still waiting when the run ends takes effect on entering IDLE.
        if (go_idle) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          count_nxt   = '0;
          clk_out_nxt = 1'b0;
          if (pend_nxt) begin
            half_nxt = pend_half_nxt;
            pend_nxt = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update order-independent within the edge.
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      half      <= CNT_W'(DEFAULT_HALF);
      pend      <= 1'b0;
      pend_half <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      half      <= half_nxt;
      pend      <= pend_nxt;
      pend_half <= pend_half_nxt;
      clk_out   <= clk_out_nxt;
      tick      <= tick_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random stimulus, all checked
// every cycle against a time-scheduled behavioural model (next toggle kept as an absolute cycle).
module tb_clk_div_ctrl;

`ifdef CLK_DIV_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic [15:0] cfg_half;
  logic        cfg_ready;
  logic [15:0] burst_len;
  logic        clk_out;
  logic        tick;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  clk_div_ctrl #(.CNT_W(16), .DEFAULT_HALF(500)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .burst_len (burst_len),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint      now = 0;
  longint      m_next;
  bit          m_valid = 0;
  bit          m_run, m_drain, m_lvl, m_tick, m_done, m_pend;
  int unsigned m_half, m_pend_half, m_blen, m_falls;

  function automatic int unsigned eff(input int unsigned h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic model_step();
    bit acc, fin;
    if (reset) begin
      m_run = 0; m_drain = 0; m_lvl = 0; m_tick = 0; m_done = 0;
      m_pend = 0; m_half = 500; m_valid = 1;
    end else if (m_valid) begin
      m_tick = 0;
      m_done = 0;
      if (!m_run) begin
        if (cfg_valid) m_half = cfg_half;
        if (start && !stop) begin
          m_run = 1; m_drain = 0; m_lvl = 0; m_falls = 0;
          m_blen = BURST ? int'(burst_len) : 0;
          m_next = now + eff(m_half);
        end
      end else begin
        acc = cfg_valid && !m_pend;
        fin = 0;
        if (stop && !m_drain && !m_lvl) begin
          fin = 1;
        end else if (now == m_next) begin
          m_lvl  = !m_lvl;
          m_tick = 1;
          if (m_pend) begin
            m_half = m_pend_half;
            m_pend = 0;
          end
          m_next = now + eff(m_half);
          if (!m_lvl) begin
            m_falls++;
            if (m_drain || stop || (m_blen != 0 && m_falls == m_blen)) fin = 1;
          end
        end else if (stop) begin
          m_drain = 1;
        end
        if (acc) begin
          m_pend      = 1;
          m_pend_half = cfg_half;
        end
        if (fin) begin
          m_run = 0; m_drain = 0; m_lvl = 0; m_done = 1;
          if (m_pend) begin
            m_half = m_pend_half;
            m_pend = 0;
          end
        end
      end
    end
    now++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("clk_out", clk_out, m_lvl);
      check("tick", tick, m_tick);
      check("done", done, m_done);
      check("busy", busy, m_run);
      check("cfg_ready", cfg_ready, !m_pend);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit s, input bit p, input bit cv, input int ch);
    start = s; stop = p; cfg_valid = cv; cfg_half = 16'(ch);
    @(negedge clk);
    start = 0; stop = 0; cfg_valid = 0;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic wait_done(input int limit, output int n, output int tk);
    n = 0;
    tk = 0;
    do begin
      @(negedge clk);
      n++;
      if (tick) tk++;
    end while (!done && n < limit);
  endtask

  initial begin
    int n, n2, tk;
    reset = 1; start = 0; stop = 0; cfg_valid = 0; cfg_half = 0; burst_len = 0;
    repeat (2) @(negedge clk);
    check("rst_clk_out", clk_out, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_done", done, 0);
    reset = 0;
    @(negedge clk);

    // Default half-period of 500.
    drive(1, 0, 0, 0);
    wait_tick(600, n);
    check("first_tick_delay", n, 500);
    check("first_tick_level", clk_out, 1);
    wait_tick(600, n);
    wait_tick(600, n2);
    check("period_500", n + n2, 1000);
    check("rise_level", clk_out, 1);
    drive(0, 1, 0, 0);
    wait_done(600, n, tk);
    check("drain_len", n, 499);
    check("drain_ticks", tk, 1);
    check("drain_clk_out", clk_out, 0);
    check("drain_busy", busy, 0);

    // half=3 set in IDLE, then stop while clk_out is low.
    drive(0, 0, 1, 3);
    check("idle_cfg_ready", cfg_ready, 1);
    drive(1, 0, 0, 0);
    wait_tick(20, n);
    check("half3_a", n, 3);
    wait_tick(20, n);
    check("half3_b", n, 3);
    drive(0, 1, 0, 0);
    check("stop_low_done", done, 1);
    check("stop_low_tick", tick, 0);
    check("stop_low_busy", busy, 0);

    // half=0 behaves as 1; stop low on a cycle where a rising toggle was due.
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      wait_tick(10, n);
      check("half0_step", n, 1);
    end
    drive(0, 1, 0, 0);
    check("half0_stop_done", done, 1);
    check("half0_stop_tick", tick, 0);

    // Mid-run reconfiguration 4 -> 2, then stop while clk_out is high.
    drive(0, 0, 1, 4);
    drive(1, 0, 0, 0);
    wait_tick(20, n);
    check("half4_first", n, 4);
    drive(0, 0, 1, 2);
    check("pending_ready", cfg_ready, 0);
    wait_tick(20, n);
    check("half4_kept", n, 3);
    check("applied_ready", cfg_ready, 1);
    wait_tick(20, n);
    check("half2_a", n, 2);
    wait_tick(20, n);
    check("half2_b", n, 2);
    wait_tick(20, n);
    check("half2_c", n, 2);
    drive(0, 1, 0, 0);
    wait_done(20, n, tk);
    check("stop_high_len", n, 1);
    check("stop_high_tick", tk, 1);

`ifdef CLK_DIV_CTRL_BURST_EN
    burst_len = 3;
    drive(1, 0, 0, 0);
    wait_done(100, n, tk);
    check("burst_ticks", tk, 6);
    check("burst_len_cycles", n, 12);
    check("burst_busy", busy, 0);
    burst_len = 0;
`endif

    // start and stop together in IDLE: stop wins.
    drive(1, 1, 0, 0);
    check("start_stop_busy", busy, 0);
    check("start_stop_done", done, 0);

    // Reset in the middle of a run with a config pending.
    drive(0, 0, 1, 5);
    drive(1, 0, 0, 0);
    repeat (3) @(negedge clk);
    drive(0, 0, 1, 7);
    check("pre_reset_pending", cfg_ready, 0);
    reset = 1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", cfg_ready, 1);
    check("mid_rst_clk_out", clk_out, 0);
    reset = 0;
    drive(1, 0, 0, 0);
    wait_tick(600, n);
    check("half_after_reset", n, 500);
    drive(0, 1, 0, 0);
    wait_done(600, n, tk);

    // Random stimulus, checked cycle by cycle against the model.
    repeat (4000) begin
      reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_half  = 16'($urandom_range(0, 6));
      burst_len = 16'($urandom_range(0, 3));
      @(negedge clk);
    end
    reset = 0; start = 0; stop = 0; cfg_valid = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
